// File: rtl/fm_spy_channel.sv
// One FM spy-buffer channel: circular capture memory with live passthrough,
// playback of the captured history, memory clear and a random-access read port.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_INIT    | writing zeros across the whole memory, one word per cycle
// ST_CAPTURE | recording data_in at wr_ptr, live passthrough
// ST_FROZEN  | recording halted, live passthrough
// ST_PB_ONCE | replaying the captured history a single time
// ST_PB_LOOP | replaying the captured history repeatedly
// ST_PB_DONE | single replay finished, output idle until mode returns to 0
module fm_spy_channel #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 10,
  parameter int PB_MODE_WIDTH = 2
) (
  input  logic                     axi_clk,
  input  logic                     axi_rst,
  input  logic                     freeze,
  input  logic [PB_MODE_WIDTH-1:0] playback_mode,
  input  logic                     init_spy_mem,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     data_in_valid,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     data_out_valid,
  input  logic                     rd_en,
  input  logic [ADDR_WIDTH-1:0]    rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_data_valid,
  output logic [ADDR_WIDTH-1:0]    wr_ptr,
  output logic                     wrapped,
  output logic                     frozen,
  output logic                     pb_active,
  output logic                     init_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_CAPTURE,
    ST_FROZEN,
    ST_PB_ONCE,
    ST_PB_LOOP,
    ST_PB_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic                    init_q;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic                    wrapped_q, wrapped_d;
  logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
  logic [ADDR_WIDTH-1:0]   pb_addr_q, pb_addr_d;
  logic [ADDR_WIDTH-1:0]   pb_start_q, pb_start_d;
  logic [CNT_W-1:0]        pb_len_q, pb_len_d;
  logic [CNT_W-1:0]        pb_rem_q, pb_rem_d;
  logic                    pipe_v_q;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                    data_out_valid_q, data_out_valid_d;
  logic                    rd_valid_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   ram_a_q;
  logic [DATA_WIDTH-1:0]   ram_b_q;

  logic                    we_a;
  logic [ADDR_WIDTH-1:0]   addr_a;
  logic [DATA_WIDTH-1:0]   wdata_a;
  logic                    issue;

  logic                    init_edge;
  logic                    mode_play;
  logic                    mode_loop;
  logic [CNT_W-1:0]        len_now;
  logic [ADDR_WIDTH-1:0]   start_now;
  state_t                  abort_state;

  assign init_edge   = init_spy_mem & ~init_q;
  // Mode 3 is treated exactly like mode 0.
  assign mode_play   = (playback_mode == PB_MODE_WIDTH'(1)) || (playback_mode == PB_MODE_WIDTH'(2));
  assign mode_loop   = (playback_mode == PB_MODE_WIDTH'(2));
  assign len_now     = wrapped_q ? CNT_W'(DEPTH) : {1'b0, wr_ptr_q};
  assign start_now   = wrapped_q ? wr_ptr_q : '0;
  assign abort_state = freeze ? ST_FROZEN : ST_CAPTURE;

  always_comb begin
    state_d          = state_q;
    wr_ptr_d         = wr_ptr_q;
    wrapped_d        = wrapped_q;
    init_cnt_d       = init_cnt_q;
    pb_addr_d        = pb_addr_q;
    pb_start_d       = pb_start_q;
    pb_len_d         = pb_len_q;
    pb_rem_d         = pb_rem_q;
    we_a             = 1'b0;
    addr_a           = pb_addr_q;
    wdata_a          = data_in;
    issue            = 1'b0;
    data_out_d       = data_out_q;
    data_out_valid_d = 1'b0;

    if (init_edge) begin
      state_d    = ST_INIT;
      init_cnt_d = '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          we_a       = 1'b1;
          addr_a     = init_cnt_q;
          wdata_a    = '0;
          init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
          if (&init_cnt_q) begin
            wr_ptr_d  = '0;
            wrapped_d = 1'b0;
            state_d   = abort_state;
          end
        end

        ST_CAPTURE, ST_FROZEN: begin
          data_out_d       = data_in;
          data_out_valid_d = data_in_valid;
          if (mode_play) begin
            state_d    = mode_loop ? ST_PB_LOOP : ST_PB_ONCE;
            pb_start_d = start_now;
            pb_addr_d  = start_now;
            pb_len_d   = len_now;
            pb_rem_d   = len_now;
          end else if (freeze) begin
            state_d = ST_FROZEN;
          end else begin
            state_d = ST_CAPTURE;
            // A word arriving in the cycle FROZEN is released is not stored.
            if (state_q == ST_CAPTURE && data_in_valid) begin
              we_a     = 1'b1;
              addr_a   = wr_ptr_q;
              wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
              if (&wr_ptr_q) wrapped_d = 1'b1;
            end
          end
        end

        ST_PB_ONCE, ST_PB_LOOP: begin
          if (!mode_play) begin
            state_d = abort_state;
          end else begin
            data_out_d       = ram_a_q;
            data_out_valid_d = pipe_v_q;
            if (pb_rem_q != '0) begin
              issue     = 1'b1;
              pb_addr_d = pb_addr_q + ADDR_WIDTH'(1);
              pb_rem_d  = pb_rem_q - CNT_W'(1);
            end
            // End of pass: the current mode decides between restart and done.
            if (pb_rem_q == '0 || pb_rem_q == CNT_W'(1)) begin
              if (mode_loop) begin
                state_d   = ST_PB_LOOP;
                pb_addr_d = pb_start_q;
                pb_rem_d  = pb_len_q;
              end else begin
                state_d = ST_PB_DONE;
              end
            end
          end
        end

        ST_PB_DONE: begin
          if (!mode_play) begin
            state_d = abort_state;
          end else begin
            data_out_d       = ram_a_q;
            data_out_valid_d = pipe_v_q;
          end
        end

        default: state_d = ST_CAPTURE;
      endcase
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state_q          <= ST_CAPTURE;
      init_q           <= 1'b0;
      wr_ptr_q         <= '0;
      wrapped_q        <= 1'b0;
      init_cnt_q       <= '0;
      pb_addr_q        <= '0;
      pb_start_q       <= '0;
      pb_len_q         <= '0;
      pb_rem_q         <= '0;
      pipe_v_q         <= 1'b0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      rd_valid_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      init_q           <= init_spy_mem;
      wr_ptr_q         <= wr_ptr_d;
      wrapped_q        <= wrapped_d;
      init_cnt_q       <= init_cnt_d;
      pb_addr_q        <= pb_addr_d;
      pb_start_q       <= pb_start_d;
      pb_len_q         <= pb_len_d;
      pb_rem_q         <= pb_rem_d;
      pipe_v_q         <= issue;
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
      rd_valid_q       <= rd_en;
    end
  end

  // Dual-port RAM: port A capture/init/playback, port B AXI readout (read-before-write).
  always_ff @(posedge axi_clk) begin
    if (we_a && !axi_rst) mem[addr_a] <= wdata_a;
    ram_a_q <= mem[addr_a];
    if (rd_en) ram_b_q <= mem[rd_addr];
  end

  assign data_out       = data_out_q;
  assign data_out_valid = data_out_valid_q;
  assign rd_data        = rd_valid_q ? ram_b_q : '0;
  assign rd_data_valid  = rd_valid_q;
  assign wr_ptr         = wr_ptr_q;
  assign wrapped        = wrapped_q;
  assign frozen         = (state_q == ST_FROZEN);
  assign pb_active      = (state_q == ST_PB_ONCE) || (state_q == ST_PB_LOOP) || (state_q == ST_PB_DONE);
  assign init_busy      = (state_q == ST_INIT);

endmodule

// File: tb/tb_fm_spy_channel.sv
// Scoreboard bench for fm_spy_channel (16-word memory): expected output and
// readout words are queued with their due cycle and checked by a monitor.
module tb_fm_spy_channel;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int PW    = 2;
  localparam int DEPTH = 16;

  logic          axi_clk = 1'b0;
  logic          axi_rst;
  logic          freeze;
  logic [PW-1:0] playback_mode;
  logic          init_spy_mem;
  logic [DW-1:0] data_in;
  logic          data_in_valid;
  logic [DW-1:0] data_out;
  logic          data_out_valid;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic [AW-1:0] wr_ptr;
  logic          wrapped;
  logic          frozen;
  logic          pb_active;
  logic          init_busy;

  fm_spy_channel #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PB_MODE_WIDTH(PW)) dut (
    .axi_clk(axi_clk), .axi_rst(axi_rst), .freeze(freeze),
    .playback_mode(playback_mode), .init_spy_mem(init_spy_mem),
    .data_in(data_in), .data_in_valid(data_in_valid),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .wr_ptr(wr_ptr), .wrapped(wrapped), .frozen(frozen),
    .pb_active(pb_active), .init_busy(init_busy)
  );

  always #5 axi_clk = ~axi_clk;

  int cyc = 0;
  always @(posedge axi_clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } exp_t;

  exp_t          out_q[$];
  exp_t          rd_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] model_mem [DEPTH];
  int            model_wp = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge axi_clk) begin
    if (data_out_valid === 1'b1) begin
      if (out_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL data_out_unexpected: got 0x%0h at cycle %0d, expected no word", data_out, cyc);
      end else begin
        exp_t e;
        e = out_q.pop_front();
        chk("data_out", data_out, e.d);
        chk("data_out_cycle", cyc, e.c);
      end
    end
    if (rd_data_valid === 1'b1) begin
      if (rd_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_data_unexpected: got 0x%0h at cycle %0d, expected no response", rd_data, cyc);
      end else begin
        exp_t e;
        e = rd_q.pop_front();
        chk("rd_data", rd_data, e.d);
        chk("rd_data_cycle", cyc, e.c);
      end
    end
  end

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic push_out(input logic [DW-1:0] d, input int c);
    exp_t e;
    e.d = d;
    e.c = c;
    out_q.push_back(e);
  endtask

  task automatic live_word(input logic [DW-1:0] d, input bit store);
    data_in       = d;
    data_in_valid = 1'b1;
    push_out(d, cyc + 1);
    if (store) begin
      model_mem[model_wp] = d;
      model_wp = (model_wp + 1) % DEPTH;
    end
    tick();
    data_in_valid = 1'b0;
  endtask

  task automatic read_addr(input int a);
    exp_t e;
    rd_en   = 1'b1;
    rd_addr = a[AW-1:0];
    e.d     = model_mem[a];
    e.c     = cyc + 1;
    rd_q.push_back(e);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic playback_expect(input int start, input int count, input int c0);
    for (int i = 0; i < count; i++) push_out(model_mem[(start + i) % DEPTH], c0 + i);
  endtask

  initial begin
    int k;
    int busy_cnt;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    axi_rst       = 1'b1;
    freeze        = 1'b0;
    playback_mode = '0;
    init_spy_mem  = 1'b0;
    data_in       = '0;
    data_in_valid = 1'b0;
    rd_en         = 1'b0;
    rd_addr       = '0;
    repeat (3) tick();
    axi_rst = 1'b0;
    tick();

    chk("reset_wr_ptr", wr_ptr, 0);
    chk("reset_wrapped", wrapped, 0);
    chk("reset_frozen", frozen, 0);
    chk("reset_pb_active", pb_active, 0);
    chk("reset_init_busy", init_busy, 0);
    chk("reset_data_out_valid", data_out_valid, 0);

    // capture five words, freeze, read them back
    for (int i = 0; i < 5; i++) live_word(32'hA0 + i, 1'b1);
    freeze = 1'b1;
    repeat (2) tick();
    chk("capture_wr_ptr", wr_ptr, 5);
    chk("capture_frozen", frozen, 1);
    for (int a = 0; a < 5; a++) read_addr(a);
    tick();

    // play once: words due two cycles after the sampling edge
    k = cyc;
    playback_mode = 2'd1;
    playback_expect(0, 5, k + 3);
    repeat (10) tick();
    chk("pb_done_active", pb_active, 1);
    chk("pb_done_valid", data_out_valid, 0);
    playback_mode = 2'd0;
    freeze        = 1'b0;
    tick();
    chk("abort_pb_active", pb_active, 0);
    chk("abort_frozen", frozen, 0);
    live_word(32'h55, 1'b1);
    chk("live_wr_ptr", wr_ptr, 6);

    // init while capturing, level held high must not retrigger
    live_word(32'h77, 1'b1);
    init_spy_mem  = 1'b1;
    data_in       = 32'h78;
    data_in_valid = 1'b1;
    busy_cnt      = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (i == 4) data_in_valid = 1'b0;
      if (init_busy) busy_cnt++;
    end
    chk("init_busy_cycles", busy_cnt, DEPTH);
    init_spy_mem = 1'b0;
    tick();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_wp = 0;
    chk("init_wr_ptr", wr_ptr, 0);
    chk("init_wrapped", wrapped, 0);
    for (int a = 0; a < DEPTH; a++) read_addr(a);
    tick();

    // empty buffer: play once finishes immediately with no output
    playback_mode = 2'd1;
    repeat (4) tick();
    chk("empty_pb_active", pb_active, 1);
    playback_mode = 2'd0;
    tick();

    // wrap, then loop playback oldest-first without gaps, abort mid-pass
    for (int i = 0; i < 20; i++) live_word(i, 1'b1);
    chk("wrap_wrapped", wrapped, 1);
    chk("wrap_wr_ptr", wr_ptr, 4);
    k = cyc;
    playback_mode = 2'd2;
    playback_expect(model_wp, 20, k + 3);
    repeat (22) tick();
    chk("loop_pb_active", pb_active, 1);
    playback_mode = 2'd0;
    tick();
    chk("loop_abort_valid", data_out_valid, 0);
    chk("loop_abort_pb_active", pb_active, 0);
    tick();

    // freeze gates the write in the cycle it is sampled
    freeze = 1'b1;
    live_word(32'hF0, 1'b0);
    tick();
    chk("gate_wr_ptr", wr_ptr, 4);
    chk("gate_frozen", frozen, 1);
    freeze = 1'b0;
    tick();
    live_word(32'hF1, 1'b1);
    chk("resume_wr_ptr", wr_ptr, 5);
    read_addr(4);
    tick();

    // reset during loop playback
    k = cyc;
    playback_mode = 2'd2;
    playback_expect(model_wp, 3, k + 3);
    repeat (5) tick();
    axi_rst       = 1'b1;
    playback_mode = 2'd0;
    tick();
    chk("rst_data_out", data_out, 0);
    chk("rst_data_out_valid", data_out_valid, 0);
    chk("rst_pb_active", pb_active, 0);
    chk("rst_frozen", frozen, 0);
    chk("rst_wr_ptr", wr_ptr, 0);
    chk("rst_wrapped", wrapped, 0);
    axi_rst = 1'b0;
    tick();
    for (int a = 0; a < DEPTH; a++) read_addr(a);

    repeat (4) tick();
    chk("out_queue_drained", out_q.size(), 0);
    chk("rd_queue_drained", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
